// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receiver: frame geometry and FSM states.
package uart_receiver_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PACKET_W   = 11;
  localparam int unsigned START_IDX  = 0;
  localparam int unsigned PARITY_IDX = 9;
  localparam int unsigned STOP_IDX   = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_receiver_packet_checker.sv
// packet_checker: splits an assembled 11-bit serial packet back into its data
// byte and checks the parity and stop bits.
//   packet    in   PACKET_W  {stop, parity, D7..D0, start}
//   data      out  DATA_W    D7..D0
//   parity_ok out  1         parity bit matches the configured parity
//   stop_ok   out  1         frame delimiters are valid (stop=1, start=0)
module packet_checker
  import uart_receiver_pkg::*;
#(
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic [PACKET_W-1:0] packet,
  output logic [DATA_W-1:0]   data,
  output logic                parity_ok,
  output logic                stop_ok
);

  always_comb begin
    data      = packet[START_IDX+1 +: DATA_W];
    parity_ok = ((^data) ^ 1'(PARITY_ODD)) == packet[PARITY_IDX];
    stop_ok   = packet[STOP_IDX] & ~packet[START_IDX];
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit UART receiver, frame = start, D0..D7, parity, stop.
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-low
//   rx_en         in   receiver enable; low aborts any frame in progress
//   rx_d          in   asynchronous serial line (idles high)
//   data_out      out  last received byte (held until the next data_valid)
//   data_valid    out  one-cycle pulse per completed frame
//   parity_error  out  parity mismatch for the reported frame
//   framing_error out  stop bit was 0 for the reported frame
//   busy          out  FSM is not IDLE
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_en,
  input  logic              rx_d,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_error,
  output logic              framing_error,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  state_t              state, state_next;
  logic                sync1, sync2, line_prev;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          bit_idx;
  logic [DATA_W-1:0]   data_sr;
  logic                par_bit, stop_bit;
  logic                done;
  logic                cnt_clr, sample, frame_done;
  logic [DATA_W-1:0]   chk_data;
  logic                chk_parity_ok, chk_stop_ok;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    sample     = 1'b0;
    frame_done = 1'b0;
    if (!rx_en) begin
      state_next = IDLE;
      cnt_clr    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_clr = 1'b1;
          // line_prev tracks sync2 in every state, so a line held low
          // after a frame never looks like a new falling edge.
          if (line_prev && !sync2) state_next = START;
        end
        START: begin
          if (cnt == CNT_W'(CLKS_PER_BIT/2 - 1)) begin
            cnt_clr    = 1'b1;
            state_next = sync2 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_clr = 1'b1;
            sample  = 1'b1;
            if (bit_idx == 3'(DATA_W - 1)) state_next = PARITY;
          end
        end
        PARITY: begin
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_clr    = 1'b1;
            sample     = 1'b1;
            state_next = STOP;
          end
        end
        STOP: begin
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_clr    = 1'b1;
            sample     = 1'b1;
            frame_done = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  packet_checker #(.PARITY_ODD(PARITY_ODD)) u_checker (
    .packet    ({stop_bit, par_bit, data_sr, 1'b0}),
    .data      (chk_data),
    .parity_ok (chk_parity_ok),
    .stop_ok   (chk_stop_ok)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      line_prev     <= 1'b1;
      cnt           <= '0;
      bit_idx       <= '0;
      data_sr       <= '0;
      par_bit       <= 1'b0;
      stop_bit      <= 1'b0;
      done          <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync1     <= rx_d;
      sync2     <= sync1;
      line_prev <= sync2;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == START) bit_idx <= '0;
      if (sample) begin
        unique case (state)
          DATA: begin
            // LSB arrives first, so shift in from the top.
            data_sr <= {sync2, data_sr[DATA_W-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          PARITY:  par_bit  <= sync2;
          STOP:    stop_bit <= sync2;
          default: ;
        endcase
      end
      // Stop bit lands in the packet on the sample edge; results are
      // published one cycle later once the packet is complete.
      done       <= frame_done;
      data_valid <= done;
      if (done) begin
        data_out      <= chk_data;
        parity_error  <= ~chk_parity_ok;
        framing_error <= ~chk_stop_ok;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int CLKS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_en = 1'b0;
  logic       rx_d = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_error, framing_error, busy;

  uart_receiver #(.CLKS_PER_BIT(CLKS), .PARITY_ODD(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_en         (rx_en),
    .rx_d          (rx_d),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    int unsigned at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] last_d  = 8'h00;
  logic       last_pe = 1'b0;
  logic       last_fe = 1'b0;
  logic       prev_dv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every data_valid pulse is matched against the oldest expected frame.
  always @(negedge clk) begin
    if (reset) begin
      if (data_valid) begin
        check("dv_single_cycle", {31'd0, prev_dv}, 32'd0);
        if (q.size() == 0) begin
          check("unexpected_valid", {31'd0, data_valid}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("data_out", {24'd0, data_out}, {24'd0, e.d});
          check("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
          check("framing_error", {31'd0, framing_error}, {31'd0, e.fe});
          check("latency_cycle", cyc, e.at);
          last_d  = e.d;
          last_pe = e.pe;
          last_fe = e.fe;
        end
      end
      prev_dv = data_valid;
    end else begin
      prev_dv = 1'b0;
    end
  end

  // All tasks assume they start #1 after a rising edge and leave the same way.
  task automatic drive_bits(input logic [10:0] bits, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      rx_d = bits[i / CLKS];
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [10:0] build(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic par;
    par = (^d) ^ bad_par;
    return {~bad_stop, par, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    exp_t e;
    e.d  = d;
    e.pe = bad_par;
    e.fe = bad_stop;
    // First sampling edge is the next one; valid appears 171 edges later.
    e.at = cyc + 1 + 171;
    q.push_back(e);
    drive_bits(build(d, bad_par, bad_stop), 11 * CLKS);
  endtask

  task automatic idle(input int n);
    rx_d = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_parity", {31'd0, parity_error}, 32'd0);
    check("rst_framing", {31'd0, framing_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    rx_en = 1'b1;
    idle(5);

    send(8'hA5, 1'b0, 1'b0);
    idle(20);
    send(8'h3C, 1'b1, 1'b0);
    idle(20);

    // Framing error, then line stuck low: must not retrigger.
    send(8'h81, 1'b0, 1'b1);
    rx_d = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("stuck_low_busy", {31'd0, busy}, 32'd0);
    idle(20);

    // Start-bit glitch.
    rx_d = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_d = 1'b1;
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    idle(30);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_hold_data", {24'd0, data_out}, {24'd0, last_d});
    check("glitch_hold_pe", {31'd0, parity_error}, {31'd0, last_pe});
    check("glitch_hold_fe", {31'd0, framing_error}, {31'd0, last_fe});

    // Back-to-back frames, no idle gap.
    send(8'h00, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    idle(20);

    // Reset during D4.
    drive_bits(build(8'hC3, 1'b0, 1'b0), 5 * CLKS + CLKS / 2);
    reset = 1'b0;
    rx_d  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    check("midrst_parity", {31'd0, parity_error}, 32'd0);
    check("midrst_framing", {31'd0, framing_error}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle(30);
    send(8'h5A, 1'b0, 1'b0);
    idle(20);

    // rx_en drop during D4.
    drive_bits(build(8'h96, 1'b1, 1'b0), 5 * CLKS + CLKS / 2);
    rx_en = 1'b0;
    rx_d  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    rx_en = 1'b1;
    idle(30);
    check("abort_hold_data", {24'd0, data_out}, {24'd0, last_d});
    send(8'h5A, 1'b0, 1'b0);
    idle(5);

    // Randomized frames.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit bp, bs;
      d  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 4) == 0);
      send(d, bp, bs);
      idle(bs ? 5 : int'($urandom_range(0, 20)));
    end

    for (int t = 0; t < 500 && q.size() != 0; t++) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
